// File: rtl/vrs_pkg.sv
// Shared types and default sizing for the vector register stream block.
package vrs_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_REG    = 8;
    localparam int DEF_NUM_ELE    = 32;
    localparam int DEF_NUM_RD     = 2;

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_e;

    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_FILL = 1'b1
    } wr_state_e;

endpackage

// File: rtl/vrs_read_port.sv
// One read stream port: latches a register/length request and walks the
// element index, holding back beats that would overtake an in-progress fill.
module vrs_read_port
    import vrs_pkg::*;
#(
    parameter int  NUM_REG = DEF_NUM_REG,
    parameter int  NUM_ELE = DEF_NUM_ELE,
    localparam int RW      = $clog2(NUM_REG),
    localparam int EW      = $clog2(NUM_ELE),
    localparam int LW      = EW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [RW-1:0] req_reg,
    input  logic [LW-1:0] req_vl,
    output logic          valid,
    input  logic          ready,
    output logic          last,
    output logic          streaming,
    output logic [RW-1:0] cur_reg,
    output logic [EW-1:0] cur_idx,
    input  logic          wr_fill,
    input  logic [RW-1:0] wr_reg,
    input  logic [LW-1:0] wr_idx
);

    rd_state_e     state_q, state_d;
    logic [RW-1:0] reg_q, reg_d;
    logic [EW-1:0] idx_q, idx_d;
    logic [LW-1:0] vl_q, vl_d;
    logic [LW-1:0] req_vl_c;
    logic          chain_hold;

    assign cur_reg = reg_q;
    assign cur_idx = idx_q;

    // Next state, beat qualification and chaining hold against the writer
    always_comb begin
        state_d    = state_q;
        reg_d      = reg_q;
        idx_d      = idx_q;
        vl_d       = vl_q;
        req_vl_c   = (req_vl > LW'(NUM_ELE)) ? LW'(NUM_ELE) : req_vl;
        streaming  = (state_q == RD_STREAM);
        req_ready  = (state_q == RD_IDLE);
        // An element not yet written by the active fill must not be presented
        chain_hold = wr_fill && (wr_reg == reg_q) && ({1'b0, idx_q} >= wr_idx);
        valid      = streaming && !chain_hold;
        last       = streaming && ({1'b0, idx_q} == (vl_q - LW'(1)));
        case (state_q)
            RD_IDLE: begin
                if (req_valid) begin
                    reg_d = req_reg;
                    vl_d  = req_vl_c;
                    idx_d = '0;
                    // Zero-length requests complete on acceptance
                    if (req_vl_c != '0) state_d = RD_STREAM;
                end
            end
            RD_STREAM: begin
                if (valid && ready) begin
                    if (last) begin
                        state_d = RD_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + EW'(1);
                    end
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    // Port state registers; reset abandons any stream in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RD_IDLE;
            reg_q   <= '0;
            idx_q   <= '0;
            vl_q    <= '0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            idx_q   <= idx_d;
            vl_q    <= vl_d;
        end
    end

endmodule

// File: rtl/vector_reg_stream.sv
// Vector register file with NUM_RD streaming read ports and one streaming
// write port, WAR protection on write acceptance and RAW read chaining.
module vector_reg_stream
    import vrs_pkg::*;
#(
    parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int  NUM_REG    = DEF_NUM_REG,
    parameter int  NUM_ELE    = DEF_NUM_ELE,
    parameter int  NUM_RD     = DEF_NUM_RD,
    localparam int RW         = $clog2(NUM_REG),
    localparam int EW         = $clog2(NUM_ELE),
    localparam int LW         = EW + 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_RD-1:0]              rd_req_valid,
    output logic [NUM_RD-1:0]              rd_req_ready,
    input  logic [NUM_RD*RW-1:0]           rd_req_reg,
    input  logic [NUM_RD*LW-1:0]           rd_req_vl,
    output logic [NUM_RD-1:0]              rd_valid,
    input  logic [NUM_RD-1:0]              rd_ready,
    output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
    output logic [NUM_RD-1:0]              rd_last,
    input  logic                           wr_req_valid,
    output logic                           wr_req_ready,
    input  logic [RW-1:0]                  wr_req_reg,
    input  logic [LW-1:0]                  wr_req_vl,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic [DATA_WIDTH-1:0]          wr_data
);

    wr_state_e     wstate_q, wstate_d;
    logic [RW-1:0] wreg_q, wreg_d;
    logic [LW-1:0] wvl_q, wvl_d;
    logic [LW-1:0] widx_q, widx_d;
    logic [LW-1:0] wr_vl_c;
    logic          war_hit;
    logic          wr_beat;

    logic [NUM_REG-1:0][NUM_ELE-1:0][DATA_WIDTH-1:0] mem_q, mem_d;

    logic [NUM_RD-1:0]         rd_stream;
    logic [NUM_RD-1:0][RW-1:0] rd_reg;
    logic [NUM_RD-1:0][EW-1:0] rd_idx;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        vrs_read_port #(
            .NUM_REG (NUM_REG),
            .NUM_ELE (NUM_ELE)
        ) u_port (
            .clk       (clk),
            .reset     (reset),
            .req_valid (rd_req_valid[p]),
            .req_ready (rd_req_ready[p]),
            .req_reg   (rd_req_reg[p*RW +: RW]),
            .req_vl    (rd_req_vl[p*LW +: LW]),
            .valid     (rd_valid[p]),
            .ready     (rd_ready[p]),
            .last      (rd_last[p]),
            .streaming (rd_stream[p]),
            .cur_reg   (rd_reg[p]),
            .cur_idx   (rd_idx[p]),
            .wr_fill   (wstate_q == WR_FILL),
            .wr_reg    (wreg_q),
            .wr_idx    (widx_q)
        );
    end

    // WAR: block the write while any port streams, or is being handed, that register
    always_comb begin
        war_hit = 1'b0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (rd_stream[p] && (rd_reg[p] == wr_req_reg)) war_hit = 1'b1;
            if (rd_req_valid[p] && rd_req_ready[p] &&
                (rd_req_reg[p*RW +: RW] == wr_req_reg)) war_hit = 1'b1;
        end
    end

    // Write FSM next state and storage update
    always_comb begin
        wstate_d     = wstate_q;
        wreg_d       = wreg_q;
        wvl_d        = wvl_q;
        widx_d       = widx_q;
        mem_d        = mem_q;
        wr_vl_c      = (wr_req_vl > LW'(NUM_ELE)) ? LW'(NUM_ELE) : wr_req_vl;
        wr_req_ready = (wstate_q == WR_IDLE) && !war_hit;
        wr_ready     = (wstate_q == WR_FILL);
        wr_beat      = wr_ready && wr_valid;
        case (wstate_q)
            WR_IDLE: begin
                if (wr_req_valid && wr_req_ready) begin
                    wreg_d = wr_req_reg;
                    wvl_d  = wr_vl_c;
                    widx_d = '0;
                    if (wr_vl_c != '0) wstate_d = WR_FILL;
                end
            end
            WR_FILL: begin
                if (wr_valid) begin
                    mem_d[wreg_q][widx_q[EW-1:0]] = wr_data;
                    if (widx_q == (wvl_q - LW'(1))) begin
                        wstate_d = WR_IDLE;
                        widx_d   = '0;
                    end else begin
                        widx_d = widx_q + LW'(1);
                    end
                end
            end
            default: wstate_d = WR_IDLE;
        endcase
    end

    // Read data mux with write-through bypass of a same-cycle write to the element
    always_comb begin
        rd_data = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (rd_stream[p]) begin
                if (wr_beat && (wreg_q == rd_reg[p]) && (widx_q == {1'b0, rd_idx[p]}))
                    rd_data[p*DATA_WIDTH +: DATA_WIDTH] = wr_data;
                else
                    rd_data[p*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_reg[p]][rd_idx[p]];
            end
        end
    end

    // Write FSM and storage registers; reset wipes the whole register file
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wstate_q <= WR_IDLE;
            wreg_q   <= '0;
            wvl_q    <= '0;
            widx_q   <= '0;
            mem_q    <= '0;
        end else begin
            wstate_q <= wstate_d;
            wreg_q   <= wreg_d;
            wvl_q    <= wvl_d;
            widx_q   <= widx_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: tb/tb_vector_reg_stream.sv
// Bench for vector_reg_stream: element-level model of the register file,
// a table of single-cycle handshake vectors and directed/random streams.
module tb_vector_reg_stream;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  rd_req_valid, rd_req_ready, rd_valid, rd_ready, rd_last;
    logic [5:0]  rd_req_reg;
    logic [11:0] rd_req_vl;
    logic [63:0] rd_data;
    logic        wr_req_valid, wr_req_ready, wr_valid, wr_ready;
    logic [2:0]  wr_req_reg;
    logic [5:0]  wr_req_vl;
    logic [31:0] wr_data;

    logic       rqv [2];
    logic [2:0] rqr [2];
    logic [5:0] rqvl[2];
    logic       rdy [2];

    int          total = 0;
    int          bad = 0;
    logic [31:0] mdl[8][32];
    int          wr_done = 0;
    bit          rd_active[2];
    bit          chain_chk = 0;
    bit          war_chk = 0;

    vector_reg_stream dut (
        .clk(clk), .reset(reset),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_req_reg(rd_req_reg), .rd_req_vl(rd_req_vl),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
        .wr_req_reg(wr_req_reg), .wr_req_vl(wr_req_vl),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_req_valid[p]      = rqv[p];
            rd_req_reg[p*3 +: 3] = rqr[p];
            rd_req_vl[p*6 +: 6]  = rqvl[p];
            rd_ready[p]          = rdy[p];
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    function automatic logic [31:0] dat(input int p);
        return rd_data[p*32 +: 32];
    endfunction

    function automatic int clampv(input int vl);
        return (vl > 32) ? 32 : vl;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Request a write and feed its beats; rnd selects random data, else base+i
    task automatic wr_run(input int r, input int vl, input int gap, input bit rnd,
                          input logic [31:0] base, output int wait_cyc);
        int          n;
        logic [31:0] d;
        n = clampv(vl);
        @(posedge clk); #1;
        wr_req_valid = 1'b1; wr_req_reg = 3'(r); wr_req_vl = 6'(vl);
        @(negedge clk);
        wait_cyc = 0;
        while (!wr_req_ready && wait_cyc < 300) begin
            @(negedge clk);
            wait_cyc++;
        end
        chk("wr_req_ready", wr_req_ready, 1);
        if (war_chk) chk("war_release", rd_active[0] | rd_active[1], 0);
        @(posedge clk); #1;
        wr_req_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            d = rnd ? $urandom : base + 32'(i);
            wr_valid = 1'b1; wr_data = d;
            @(negedge clk);
            chk("wr_ready", wr_ready, 1);
            @(posedge clk);
            mdl[r][i] = d;
            wr_done = i + 1;
            #1 wr_valid = 1'b0;
            if (gap > 1) begin
                repeat (gap - 1) @(posedge clk);
                #1;
            end
        end
        @(negedge clk);
        chk("wr_idle", wr_ready, 0);
    endtask

    // Request a read stream and check each beat against the model
    task automatic rd_run(input int p, input int r, input int vl, input int stall_at,
                          input int abort_at, output int lat);
        int n, exp_n, cyc, st;
        exp_n = clampv(vl); n = 0; st = 0; lat = -1;
        @(posedge clk); #1;
        rqv[p] = 1'b1; rqr[p] = 3'(r); rqvl[p] = 6'(vl);
        @(negedge clk);
        cyc = 0;
        while (!rd_req_ready[p] && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk("rd_req_ready", rd_req_ready[p], 1);
        @(posedge clk); #1;
        rqv[p] = 1'b0;
        rd_active[p] = (exp_n != 0);
        cyc = 0;
        while (n < exp_n && cyc < 600) begin
            rdy[p] = !(n == stall_at && st < 5);
            if (!rdy[p]) st++;
            @(negedge clk);
            if (chain_chk && !rd_valid[p] && wr_valid && wr_ready && n == wr_done)
                chk("bypass", dat(p), wr_data);
            if (rd_valid[p]) begin
                if (lat < 0) lat = cyc;
                if (chain_chk) chk("chain_lead", n < wr_done, 1);
                chk("rd_data", dat(p), mdl[r][n]);
                if (abort_at == n) begin
                    reset = 1'b1;
                    #1;
                    chk("abort_valid", rd_valid[p], 0);
                    chk("abort_last", rd_last[p], 0);
                    chk("abort_data", dat(p), 0);
                    chk("abort_req_ready", rd_req_ready, 2'b11);
                    chk("abort_wr_req_ready", wr_req_ready, 1);
                    rdy[p] = 1'b0;
                    rd_active[p] = 1'b0;
                    return;
                end
                if (rdy[p]) begin
                    chk("rd_last", rd_last[p], n == exp_n - 1);
                    n++;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("rd_count", n, exp_n);
        rdy[p] = 1'b0;
        rd_active[p] = 1'b0;
        @(negedge clk);
        chk("rd_no_extra", rd_valid[p], 0);
        if (exp_n == 0) begin
            repeat (3) begin
                chk("vl0_req_ready", rd_req_ready[p], 1);
                @(negedge clk);
                chk("vl0_no_valid", rd_valid[p], 0);
            end
        end
    endtask

    typedef struct {
        logic [1:0] rv;
        logic [2:0] rr0;
        logic [2:0] rr1;
        logic       wv;
        logic [2:0] wr;
        logic       exp_wrr;
    } vec_t;

    initial begin
        vec_t tbl[6];
        int   lat0, lat1, w;
        int   r, vl, r0, vl0, st0, r1, vl1;

        tbl[0] = '{rv: 2'b01, rr0: 3'd3, rr1: 3'd0, wv: 1'b1, wr: 3'd3, exp_wrr: 1'b0};
        tbl[1] = '{rv: 2'b01, rr0: 3'd3, rr1: 3'd0, wv: 1'b1, wr: 3'd4, exp_wrr: 1'b1};
        tbl[2] = '{rv: 2'b10, rr0: 3'd0, rr1: 3'd7, wv: 1'b1, wr: 3'd7, exp_wrr: 1'b0};
        tbl[3] = '{rv: 2'b00, rr0: 3'd0, rr1: 3'd0, wv: 1'b1, wr: 3'd0, exp_wrr: 1'b1};
        tbl[4] = '{rv: 2'b11, rr0: 3'd1, rr1: 3'd1, wv: 1'b0, wr: 3'd1, exp_wrr: 1'b0};
        tbl[5] = '{rv: 2'b11, rr0: 3'd2, rr1: 3'd6, wv: 1'b1, wr: 3'd5, exp_wrr: 1'b1};

        for (int p = 0; p < 2; p++) begin
            rqv[p] = 0; rqr[p] = 0; rqvl[p] = 0; rdy[p] = 0; rd_active[p] = 0;
        end
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 32; j++) mdl[i][j] = '0;
        wr_req_valid = 0; wr_req_reg = 0; wr_req_vl = 0; wr_valid = 0; wr_data = 0;

        // Reset values
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_rd_req_ready", rd_req_ready, 2'b11);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_last", rd_last, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_wr_req_ready", wr_req_ready, 1);
        chk("rst_wr_ready", wr_ready, 0);
        @(posedge clk); #1 reset = 1'b0;

        // Single-cycle WAR / zero-length vectors
        foreach (tbl[k]) begin
            @(posedge clk); #1;
            rqv[0] = tbl[k].rv[0]; rqr[0] = tbl[k].rr0; rqvl[0] = 0;
            rqv[1] = tbl[k].rv[1]; rqr[1] = tbl[k].rr1; rqvl[1] = 0;
            wr_req_valid = tbl[k].wv; wr_req_reg = tbl[k].wr; wr_req_vl = 0;
            @(negedge clk);
            chk("tbl_wr_req_ready", wr_req_ready, tbl[k].exp_wrr);
            chk("tbl_rd_req_ready", rd_req_ready, 2'b11);
            @(posedge clk); #1;
            rqv[0] = 0; rqv[1] = 0; wr_req_valid = 0;
            @(negedge clk);
            chk("tbl_idle_rd_valid", rd_valid, 0);
            chk("tbl_idle_wr_ready", wr_ready, 0);
            chk("tbl_idle_rd_req_ready", rd_req_ready, 2'b11);
        end

        // Basic write then read, latency 1
        wr_run(3, 4, 1, 0, 32'h10, w);
        rd_run(0, 3, 4, -1, -1, lat0);
        chk("first_beat_latency", lat0, 0);

        // Two ports on one register hold off a write until both finish
        wr_run(2, 8, 1, 1, 0, w);
        war_chk = 1;
        fork
            rd_run(0, 2, 8, -1, -1, lat0);
            rd_run(1, 2, 3, -1, -1, lat1);
            begin
                repeat (3) @(posedge clk);
                wr_run(2, 2, 1, 1, 0, w);
            end
        join
        war_chk = 0;
        chk("war_held", w > 0, 1);

        // Chained read behind a slow fill
        wr_done = 0;
        fork
            wr_run(5, 6, 2, 1, 0, w);
            begin
                for (int c = 0; c < 100 && wr_done < 1; c++) @(posedge clk);
                chk("chain_start", wr_done >= 1, 1);
                chain_chk = 1;
                rd_run(0, 5, 6, -1, -1, lat0);
                chain_chk = 0;
            end
        join

        // Length clamp and zero length
        wr_run(6, 40, 1, 1, 0, w);
        rd_run(1, 6, 40, -1, -1, lat1);
        rd_run(0, 6, 0, -1, -1, lat0);

        // Consumer stall mid-stream
        rd_run(0, 6, 12, 4, -1, lat0);

        // Random writes and concurrent reads against the model
        for (int it = 0; it < 12; it++) begin
            r = $urandom_range(0, 7); vl = $urandom_range(0, 40);
            wr_run(r, vl, $urandom_range(1, 2), 1, 0, w);
            r0 = $urandom_range(0, 7); vl0 = $urandom_range(0, 40); st0 = $urandom_range(0, 10);
            r1 = $urandom_range(0, 7); vl1 = $urandom_range(0, 40);
            fork
                rd_run(0, r0, vl0, st0, -1, lat0);
                rd_run(1, r1, vl1, -1, -1, lat1);
            join
        end

        // Reset on the third beat of an 8-beat read wipes storage
        wr_run(4, 8, 1, 1, 0, w);
        rd_run(0, 4, 8, -1, 2, lat0);
        repeat (2) @(posedge clk);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 32; j++) mdl[i][j] = '0;
        #1 reset = 1'b0;
        rd_run(0, 4, 8, -1, -1, lat0);
        rd_run(1, 6, 32, -1, -1, lat1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vector_reg_stream.md
VECTOR_REG_STREAM -- requirements
Module: vector_reg_stream

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_WIDTH, 32, element width
- NUM_REG, 8, number of vector registers
- NUM_ELE, 32, elements per register
- NUM_RD, 2, number of read stream ports
REQ-002 Derived widths SHALL be RW = clog2(NUM_REG), EW = clog2(NUM_ELE), LW = EW+1.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge
- reset, in, 1, asynchronous, active-high reset
- rd_req_valid, in, NUM_RD, per-port read request
- rd_req_ready, out, NUM_RD, read request accepted
- rd_req_reg, in, NUM_RD*RW, source register per port
- rd_req_vl, in, NUM_RD*LW, element count per port
- rd_valid, out, NUM_RD, element beat valid
- rd_ready, in, NUM_RD, consumer ready
- rd_data, out, NUM_RD*DATA_WIDTH, element data
- rd_last, out, NUM_RD, final beat of stream
- wr_req_valid, in, 1, write request
- wr_req_ready, out, 1, write request accepted
- wr_req_reg, in, RW, destination register
- wr_req_vl, in, LW, element count
- wr_valid, in, 1, write beat valid
- wr_ready, out, 1, write beat accepted
- wr_data, in, DATA_WIDTH, element data

Function
REQ-004 Storage SHALL be NUM_REG x NUM_ELE elements of DATA_WIDTH bits.
REQ-005 Each read port SHALL run an FSM with states IDLE and STREAM; the write port SHALL run an FSM with states IDLE and FILL.
REQ-006 A request SHALL be accepted when valid && ready; rd_req_ready[p] SHALL be 1 only in IDLE, and wr_req_ready SHALL be 1 only in IDLE with no WAR hazard (REQ-011).
REQ-007 A request vl above NUM_ELE SHALL be clamped to NUM_ELE; vl=0 SHALL be accepted and the FSM SHALL stay IDLE with no beats.
REQ-008 In STREAM, rd_data SHALL be element idx of the latched register; idx SHALL start at 0 and advance on rd_valid && rd_ready; rd_last SHALL be 1 when idx == vl-1; a handshake on the last beat SHALL return the FSM to IDLE.
REQ-009 The first read beat SHALL be presentable in the cycle after acceptance (latency 1).
REQ-010 In FILL, the beat with wr_valid && wr_ready SHALL write wr_data to element widx and increment widx; wr_ready SHALL be 1 throughout FILL; the beat widx == vl-1 SHALL return the FSM to IDLE.
REQ-011 WAR: wr_req_ready SHALL be 0 while any read port is in STREAM on wr_req_reg, or accepts a read of wr_req_reg in the same cycle.
REQ-012 RAW chaining: a read port in STREAM on the register currently in FILL SHALL assert rd_valid only while idx < widx, else rd_valid = 1 in STREAM.
REQ-013 A write beat to element k and a read of element k in the same cycle SHALL return the new data (write-through bypass).
REQ-014 Multiple read ports SHALL stream the same register concurrently and independently.
REQ-015 When the write FSM completes, chaining gating SHALL release in the next cycle.

Reset
REQ-016 Asserting reset SHALL immediately force all FSMs to IDLE, clear idx, widx and latched vl/reg, and clear all storage to 0.
REQ-017 During reset, outputs SHALL be: rd_req_ready=all 1s, rd_valid=0, rd_last=0, rd_data=0, wr_req_ready=1, wr_ready=0.
REQ-018 Reset mid-stream SHALL abandon the stream with no further beats; partially written registers SHALL read 0.

Structure
REQ-019 A shared package SHALL hold the FSM state enums and the default parameter constants.
REQ-020 The read FSM SHALL be one sub-module, vrs_read_port, instantiated NUM_RD times via generate.

Verification
REQ-021 Write reg 3 with vl=4, data 0x10..0x13, then read reg 3 with vl=4 on port 0 -> beats 0x10,0x11,0x12,0x13, rd_last on the 4th beat, first beat one cycle after acceptance.
REQ-022 Port 0 reads reg 2 with vl=8 while port 1 reads reg 2 with vl=3 -> wr_req for reg 2 is held not ready until both ports are IDLE, then it is accepted.
REQ-023 Write reg 5 with vl=6 at 1 beat every 2 cycles; read reg 5 accepted after the first write beat -> rd_valid never leads widx, and the read data equals the write data in order.
REQ-024 Read request with vl=40 on NUM_ELE=32 -> exactly 32 beats; read request with vl=0 -> rd_req_ready stays 1 and no rd_valid.
REQ-025 Reset asserted on the 3rd beat of an 8-beat read -> rd_valid=0 immediately, and a read of any register after reset returns 0.
REQ-026 rd_ready held 0 for 5 cycles mid-stream -> rd_data and idx stay stable and no beat is lost.
